// File: rtl/subleq_prog_loader_pkg.sv
// Shared definitions for the SUBLEQ/URISC core and its program loader:
// instruction field bounds, memory geometry, loader FSM states and the
// instruction packing helper (also used by the core's decoder tests).
package gc;

   localparam int WORD_SIZE = 64;
   localparam int ARG_SIZE  = 20;
   localparam int MEM_SIZE  = 36;

   // Operand field bounds inside an instruction word.
   localparam int A_LB = 0;
   localparam int A_UB = 19;
   localparam int B_LB = 20;
   localparam int B_UB = 39;
   localparam int C_LB = 40;
   localparam int C_UB = 59;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GET_A = 3'd1,
      GET_B = 3'd2,
      GET_C = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5
   } loader_state_t;

   // Place A, B, C into their fields; the top nibble is always zero.
   function automatic logic [WORD_SIZE-1:0] pack_instr(
      input logic [ARG_SIZE-1:0] a,
      input logic [ARG_SIZE-1:0] b,
      input logic [ARG_SIZE-1:0] c
   );
      logic [WORD_SIZE-1:0] w;
      w = '0;
      w[A_UB:A_LB] = a;
      w[B_UB:B_LB] = b;
      w[C_UB:C_LB] = c;
      return w;
   endfunction

endpackage

// File: rtl/subleq_prog_loader.sv
// Purpose: packs a host operand stream (A,B,C) into instruction words, writes them from addr 0,
// Latency: write strobe 1 cycle after the C operand is accepted; holds the core until done.
// Backpressure: valid/ready; op_ready low outside GET_A/B/C. Option: SUBLEQ_LOADER_CHECKSUM_EN.
module subleq_prog_loader
   import gc::*;
#(
   parameter int WORD_SIZE = gc::WORD_SIZE,
   parameter int ARG_SIZE  = gc::ARG_SIZE,
   parameter int MEM_SIZE  = gc::MEM_SIZE,
   parameter int ADDR_W    = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 op_valid,
   input  logic [ARG_SIZE-1:0]  op_data,
   input  logic                 op_last,
   output logic                 op_ready,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   output logic                 core_hold,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow,
   output logic                 partial,
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
   output logic [WORD_SIZE-1:0] checksum,
`endif
   output logic [ADDR_W:0]      word_count
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

   loader_state_t        state_q, state_d;
   logic [ARG_SIZE-1:0]  a_q, a_d;
   logic [ARG_SIZE-1:0]  b_q, b_d;
   logic [ARG_SIZE-1:0]  c_q, c_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [ADDR_W:0]      word_count_q, word_count_d;
   logic                 overflow_q, overflow_d;
   logic                 partial_q, partial_d;
   logic                 last_q, last_d;
   logic [WORD_SIZE-1:0] word;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
   logic [WORD_SIZE-1:0] checksum_q, checksum_d;
`endif

   assign word = pack_instr(a_q, b_q, c_q);

   // Next-state logic: operand capture, write sequencing and session flags.
   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      c_d          = c_q;
      addr_d       = addr_q;
      word_count_d = word_count_q;
      overflow_d   = overflow_q;
      partial_d    = partial_q;
      last_d       = last_q;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
      checksum_d   = checksum_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d      = GET_A;
               a_d          = '0;
               b_d          = '0;
               c_d          = '0;
               addr_d       = '0;
               word_count_d = '0;
               overflow_d   = 1'b0;
               partial_d    = 1'b0;
               last_d       = 1'b0;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
               checksum_d   = '0;
`endif
            end
         end
         GET_A: begin
            if (op_valid) begin
               a_d = op_data;
               if (op_last) begin
                  last_d    = 1'b1;
                  partial_d = 1'b1;
                  state_d   = WRITE;
               end else begin
                  state_d = GET_B;
               end
            end
         end
         GET_B: begin
            if (op_valid) begin
               b_d = op_data;
               if (op_last) begin
                  last_d    = 1'b1;
                  partial_d = 1'b1;
                  state_d   = WRITE;
               end else begin
                  state_d = GET_C;
               end
            end
         end
         GET_C: begin
            if (op_valid) begin
               c_d     = op_data;
               last_d  = op_last;
               state_d = WRITE;
            end
         end
         WRITE: begin
            addr_d       = addr_q + 1'b1;
            word_count_d = word_count_q + 1'b1;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
            checksum_d   = checksum_q ^ word;
`endif
            if (last_q) begin
               state_d = DONE;
            end else if (addr_q == LAST_ADDR) begin
               // Memory is full: stop here and leave the next operand pending.
               state_d    = DONE;
               overflow_d = 1'b1;
            end else begin
               state_d = GET_A;
               a_d     = '0;
               b_d     = '0;
               c_d     = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         c_q          <= '0;
         addr_q       <= '0;
         word_count_q <= '0;
         overflow_q   <= 1'b0;
         partial_q    <= 1'b0;
         last_q       <= 1'b0;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
         checksum_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         c_q          <= c_d;
         addr_q       <= addr_d;
         word_count_q <= word_count_d;
         overflow_q   <= overflow_d;
         partial_q    <= partial_d;
         last_q       <= last_d;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
         checksum_q   <= checksum_d;
`endif
      end
   end

   // Outputs decoded from the current state and registers.
   always_comb begin
      op_ready   = (state_q == GET_A) || (state_q == GET_B) || (state_q == GET_C);
      mem_we     = (state_q == WRITE);
      busy       = op_ready || mem_we;
      done       = (state_q == DONE);
      core_hold  = (state_q != DONE);
      mem_addr   = addr_q;
      mem_wdata  = word;
      overflow   = overflow_q;
      partial    = partial_q;
      word_count = word_count_q;
   end

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
   assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_subleq_prog_loader.sv
// Directed bench for subleq_prog_loader: basic load, back-to-back valid,
// partial program, overflow, mid-session reset and (when enabled) checksum.
module tb_subleq_prog_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        op_valid;
   logic [19:0] op_data;
   logic        op_last;
   logic        op_ready;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic        core_hold;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        partial;
   logic [6:0]  word_count;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
   logic [63:0] checksum;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Write monitor
   int          wr_cnt = 0;
   logic [5:0]  wr_addr [64];
   logic [63:0] wr_data [64];
   int          wr_cyc  [64];

   subleq_prog_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .op_valid(op_valid), .op_data(op_data), .op_last(op_last),
      .op_ready(op_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .core_hold(core_hold), .busy(busy),
      .done(done), .overflow(overflow), .partial(partial),
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
      .checksum(checksum),
`endif
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we) begin
         if (wr_cnt < 64) begin
            wr_addr[wr_cnt] = mem_addr;
            wr_data[wr_cnt] = mem_wdata;
            wr_cyc[wr_cnt]  = cyc;
         end
         wr_cnt = wr_cnt + 1;
         checks = checks + 1;
         if (op_ready !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL ready_in_write: op_ready=%b required 0", op_ready);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Present one operand and wait (bounded) until it is accepted.
   task automatic send_op(input logic [19:0] d, input logic l);
      int n;
      n = 0;
      op_valid = 1'b1;
      op_data  = d;
      op_last  = l;
      while (op_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (op_ready !== 1'b1) begin
         failures++;
         $display("FAIL send_op_timeout: op_ready=%b required 1 (data %0d)", op_ready, d);
      end else begin
         tick();
      end
   endtask

   task automatic idle_bus();
      op_valid = 1'b0;
      op_last  = 1'b0;
      op_data  = '0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL done_timeout: done=%b required 1", done);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if ({op_ready, mem_we, core_hold, busy, done, overflow, partial} !== 7'b0010000 ||
          mem_addr !== 6'd0 || mem_wdata !== 64'd0 || word_count !== 7'd0) begin
         failures++;
         $display("FAIL %s: rdy=%b we=%b hold=%b busy=%b done=%b ovf=%b part=%b addr=%0d wdata=%h wc=%0d required reset values",
                  tag, op_ready, mem_we, core_hold, busy, done, overflow, partial, mem_addr, mem_wdata, word_count);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      check_reset_values("reset_state");
   endtask

   task automatic test_basic();
      wr_cnt = 0;
      pulse_start();
      checks++;
      if (busy !== 1'b1 || core_hold !== 1'b1 || op_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_start: busy=%b hold=%b rdy=%b required 1 1 1", busy, core_hold, op_ready);
      end
      send_op(20'd1, 1'b0);
      send_op(20'd2, 1'b0);
      send_op(20'd3, 1'b0);
      idle_bus();
      // One cycle after C is accepted the write strobe must be up.
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 6'd0 || mem_wdata !== {4'h0, 20'd3, 20'd2, 20'd1}) begin
         failures++;
         $display("FAIL basic_latency: we=%b addr=%0d wdata=%h required 1 0 %h",
                  mem_we, mem_addr, mem_wdata, {4'h0, 20'd3, 20'd2, 20'd1});
      end
      send_op(20'd4, 1'b0);
      send_op(20'd5, 1'b0);
      send_op(20'd6, 1'b1);
      idle_bus();
      wait_done();
      checks++;
      if (wr_cnt !== 2 || wr_addr[1] !== 6'd1 || wr_data[1] !== {4'h0, 20'd6, 20'd5, 20'd4}) begin
         failures++;
         $display("FAIL basic_word1: writes=%0d addr=%0d data=%h required 2 1 %h",
                  wr_cnt, wr_addr[1], wr_data[1], {4'h0, 20'd6, 20'd5, 20'd4});
      end
      checks++;
      if (word_count !== 7'd2 || core_hold !== 1'b0 || busy !== 1'b0 || partial !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL basic_done: wc=%0d hold=%b busy=%b part=%b ovf=%b required 2 0 0 0 0",
                  word_count, core_hold, busy, partial, overflow);
      end
      // start while busy is ignored; from DONE it opens a new session.
      pulse_start();
      checks++;
      if (core_hold !== 1'b1 || word_count !== 7'd0 || mem_addr !== 6'd0 || done !== 1'b0) begin
         failures++;
         $display("FAIL restart: hold=%b wc=%0d addr=%0d done=%b required 1 0 0 0",
                  core_hold, word_count, mem_addr, done);
      end
      pulse_start();
      checks++;
      if (op_ready !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL start_while_busy: rdy=%b busy=%b required 1 1", op_ready, busy);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      wr_cnt = 0;
      pulse_start();
      for (int i = 1; i <= 9; i++) send_op(20'(i), i == 9);
      idle_bus();
      wait_done();
      checks++;
      if (wr_cnt !== 3 || wr_data[0] !== {4'h0, 20'd3, 20'd2, 20'd1} ||
          wr_data[1] !== {4'h0, 20'd6, 20'd5, 20'd4} || wr_data[2] !== {4'h0, 20'd9, 20'd8, 20'd7}) begin
         failures++;
         $display("FAIL b2b_words: writes=%0d d0=%h d1=%h d2=%h required 3 words 1..9",
                  wr_cnt, wr_data[0], wr_data[1], wr_data[2]);
      end
      checks++;
      if (wr_cyc[1] - wr_cyc[0] !== 4 || wr_cyc[2] - wr_cyc[1] !== 4) begin
         failures++;
         $display("FAIL b2b_spacing: gaps=%0d,%0d required 4,4",
                  wr_cyc[1] - wr_cyc[0], wr_cyc[2] - wr_cyc[1]);
      end
   endtask

   task automatic test_partial();
      do_reset();
      wr_cnt = 0;
      pulse_start();
      for (int i = 7; i <= 11; i++) send_op(20'(i), i == 11);
      idle_bus();
      wait_done();
      checks++;
      if (wr_cnt !== 2 || wr_data[0] !== {4'h0, 20'd9, 20'd8, 20'd7} ||
          wr_addr[1] !== 6'd1 || wr_data[1] !== {4'h0, 20'd0, 20'd11, 20'd10}) begin
         failures++;
         $display("FAIL partial_words: writes=%0d d0=%h a1=%0d d1=%h required 2 %h 1 %h",
                  wr_cnt, wr_data[0], wr_addr[1], wr_data[1],
                  {4'h0, 20'd9, 20'd8, 20'd7}, {4'h0, 20'd0, 20'd11, 20'd10});
      end
      checks++;
      if (partial !== 1'b1 || word_count !== 7'd2 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL partial_flags: part=%b wc=%0d ovf=%b required 1 2 0", partial, word_count, overflow);
      end
   endtask

   task automatic test_overflow();
      int stuck;
      do_reset();
      wr_cnt = 0;
      pulse_start();
      for (int i = 1; i <= 108; i++) send_op(20'(i), 1'b0);
      // Operand 109 is presented but must stay pending.
      op_data  = 20'd109;
      op_valid = 1'b1;
      op_last  = 1'b0;
      stuck = 0;
      for (int k = 0; k < 6; k++) begin
         if (op_ready !== 1'b0) stuck++;
         tick();
      end
      checks++;
      if (stuck !== 0) begin
         failures++;
         $display("FAIL ovf_ready: op_ready high in %0d cycles required 0", stuck);
      end
      idle_bus();
      checks++;
      if (wr_cnt !== 36 || wr_addr[35] !== 6'd35 || wr_data[35] !== {4'h0, 20'd108, 20'd107, 20'd106}) begin
         failures++;
         $display("FAIL ovf_writes: writes=%0d a35=%0d d35=%h required 36 35 %h",
                  wr_cnt, wr_addr[35], wr_data[35], {4'h0, 20'd108, 20'd107, 20'd106});
      end
      checks++;
      if (overflow !== 1'b1 || word_count !== 7'd36 || done !== 1'b1 || partial !== 1'b0) begin
         failures++;
         $display("FAIL ovf_flags: ovf=%b wc=%0d done=%b part=%b required 1 36 1 0",
                  overflow, word_count, done, partial);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      wr_cnt = 0;
      pulse_start();
      for (int i = 1; i <= 4; i++) send_op(20'(i), 1'b0);
      idle_bus();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_reset_values("mid_reset");
      for (int k = 0; k < 6; k++) tick();
      checks++;
      if (wr_cnt !== 1 || core_hold !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_nowrite: writes=%0d hold=%b busy=%b required 1 1 0", wr_cnt, core_hold, busy);
      end
   endtask

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      do_reset();
      pulse_start();
      send_op(20'd1, 1'b0); send_op(20'd2, 1'b0); send_op(20'd3, 1'b0);
      send_op(20'd1, 1'b0); send_op(20'd2, 1'b0); send_op(20'd3, 1'b1);
      idle_bus();
      wait_done();
      checks++;
      if (checksum !== 64'd0) begin
         failures++;
         $display("FAIL checksum_cancel: checksum=%h required 0", checksum);
      end
      pulse_start();
      send_op(20'hFFFFF, 1'b0); send_op(20'd0, 1'b0); send_op(20'd0, 1'b1);
      idle_bus();
      wait_done();
      checks++;
      if (checksum !== 64'h0000_0000_000F_FFFF) begin
         failures++;
         $display("FAIL checksum_single: checksum=%h required 00000000000fffff", checksum);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      idle_bus();
      test_reset();
      test_basic();
      test_back_to_back();
      test_partial();
      test_overflow();
      test_mid_reset();
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
